// File: rtl/message_block_sequencer_pkg.sv
// Shared definitions for the message block sequencer: the default block width,
// the sequencer state encoding and the block-count saturation rule.
package message_block_sequencer_pkg;

    localparam int BLOCK_W_DEFAULT = 512;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // A requested count of zero, or one larger than the message can hold,
    // means "emit every block the message has".
    function automatic int unsigned sat_count(input int unsigned nblk,
                                              input int unsigned max_blocks);
        if (nblk == 0 || nblk > max_blocks) begin
            return max_blocks;
        end
        return nblk;
    endfunction

endpackage

// File: rtl/message_block_sequencer_block_mux.sv
// Picks one BLOCK_W slice out of a stored message. Block 0 sits in the most
// significant bits. An index past the end of the message yields zero.
module block_mux #(
    parameter int NUM_BLOCKS = 2,
    parameter int BLOCK_W    = 512,
    parameter int CNT_W      = 2
) (
    input  logic [NUM_BLOCKS*BLOCK_W-1:0] msg_i,
    input  logic [CNT_W-1:0]              idx_i,
    output logic [BLOCK_W-1:0]            block_o
);

    // Constant-offset slices compared against the index keep the mux regular.
    always_comb begin
        block_o = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (idx_i == CNT_W'(i)) begin
                block_o = msg_i[(NUM_BLOCKS-i)*BLOCK_W-1 -: BLOCK_W];
            end
        end
    end

endmodule

// File: rtl/message_block_sequencer.sv
// Message block sequencer: accepts a whole multi-block message in one beat and
// replays it one block per handshake on the output side.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1. The output side holds out_block/out_idx/out_first/out_last stable
// while out_valid=1 and out_ready=0; out_valid never drops without a transfer
// except on abort or reset. in_ready does not depend on in_valid.
module message_block_sequencer
    import message_block_sequencer_pkg::*;
#(
    parameter int NUM_BLOCKS = 2,
    parameter int BLOCK_W    = BLOCK_W_DEFAULT,
    parameter int CNT_W      = $clog2(NUM_BLOCKS + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          abort,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_BLOCKS*BLOCK_W-1:0] in_msg,
    input  logic [CNT_W-1:0]              in_nblk,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BLOCK_W-1:0]            out_block,
    output logic [CNT_W-1:0]              out_idx,
    output logic                          out_first,
    output logic                          out_last,
    output state_e                        dbg_state
);

    state_e                        state_q, state_d;
    logic [CNT_W-1:0]              idx_q, idx_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [NUM_BLOCKS*BLOCK_W-1:0] msg_q, msg_d;
    // Low during reset and for the first cycle after release, so in_ready
    // stays low until the block has seen a clock edge out of reset.
    logic                          alive_q;
    logic                          emit;
    logic                          is_last;
    logic [BLOCK_W-1:0]            mux_block;

    assign emit    = (state_q == EMIT);
    assign is_last = (idx_q == cnt_q - CNT_W'(1));

    block_mux #(
        .NUM_BLOCKS(NUM_BLOCKS),
        .BLOCK_W   (BLOCK_W),
        .CNT_W     (CNT_W)
    ) u_block_mux (
        .msg_i  (msg_q),
        .idx_i  (idx_q),
        .block_o(mux_block)
    );

    // Next-state logic; abort wins over both capture and advance.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        msg_d   = msg_q;
        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && alive_q) begin
                        msg_d   = in_msg;
                        cnt_d   = CNT_W'(sat_count(32'(in_nblk), NUM_BLOCKS));
                        idx_d   = '0;
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (is_last) begin
                            state_d = IDLE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            msg_q   <= '0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            msg_q   <= msg_d;
            alive_q <= 1'b1;
        end
    end

    // Outputs are forced quiet outside EMIT so reset and IDLE read as zero.
    always_comb begin
        in_ready  = alive_q && !emit;
        out_valid = emit;
        out_idx   = idx_q;
        out_first = emit && (idx_q == '0);
        out_last  = emit && is_last;
        out_block = emit ? mux_block : '0;
        dbg_state = state_q;
    end

endmodule
